add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
Parametrised, pipelined adder-subtractor. Splits an N-bit operation into CHUNK-bit ripple slices, with the carry registered between slices, so N can grow without lengthening the carry path. Valid/ready handshakes on input and output. Produces result, carry/borrow, signed overflow and zero flags. Sits in the datapath as a drop-in sequential successor to the combinational add_sub block.

Parameters:
N, 16, operand/result width; must be a multiple of CHUNK.
CHUNK, 4, bits per pipeline slice.
STAGES, N/CHUNK (derived localparam, not overridable), pipeline depth.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  operand transaction valid.
in_ready  out  1  block can accept a transaction this cycle.
ctrl  in  1  0 = add (a+b), 1 = subtract (a-b).
a  in  N  operand A.
b  in  N  operand B.
out_valid  out  1  result transaction valid.
out_ready  in  1  downstream accepts the result.
result  out  N  a+b or a-b, modulo 2^N.
cb_bit  out  1  add: carry out; sub: borrow (1 iff a<b unsigned).
ovf  out  1  signed two's-complement overflow.
zero  out  1  result == 0.

Behaviour:
- Reset: out_valid=0, result=0, cb_bit=0, ovf=0, zero=0, all stage valid bits=0, in_ready=0 while rst=1. Reset mid-operation discards all in-flight transactions; nothing is emitted afterwards.
- Global enable: en = !out_valid | out_ready. in_ready = en & !rst. All stage registers advance only when en=1. Bubbles are not collapsed.
- Accept: a transaction is accepted on an edge where in_valid & in_ready.
- Subtract: b' = b ^ {N{ctrl}}; carry-in to slice 0 = ctrl.
- Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] from the delayed a, b' and the registered carry from slice k-1.
  - Slice 0 is combinational on the inputs and is captured on the accept edge.
  - Lower result chunks, upper operand chunks, ctrl and the valid bit travel with the transaction.
- Latency: the output register loads STAGES-1 en-edges after the accept edge, so out_valid is visible STAGES cycles after the accept cycle when unstalled. Throughput is 1 op/cycle.
- Flags, computed in the final stage:
  - cb_bit = cout ^ ctrl.
  - ovf = (a[N-1]==b'[N-1]) & (sum[N-1]!=a[N-1]).
  - zero = (result==0), evaluated after any saturation.
- Output hold: while out_valid=1 and out_ready=0, result and all flags hold stable and in_ready=0.
- Simultaneous events: out_ready=1 and in_valid=1 in the same cycle means accept and drain on the same edge (full throughput). rst has priority over everything.
- Wrap-around: results are modulo 2^N unless saturation is compiled in and enabled.

Optional Feature:
- Macro: ADD_SUB_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the transaction and piped alongside ctrl.
  - If sat=1 and ovf=1, result clamps to 2^(N-1)-1 on positive overflow (a[N-1]=0) or -2^(N-1) on negative overflow.
  - ovf still reports 1. cb_bit is unaffected.
- Undefined: port sat does not exist; results always wrap.

Decomposition:
- Package add_sub_pkg:
  - op_e enum: OP_ADD=1'b0, OP_SUB=1'b1.
  - Packed struct flags_t {cb, ovf, zero}.
  - Function returning signed max/min for a given width.
- Sub-module add_sub_slice: CHUNK-wide combinational ripple adder with inputs a, b', cin and outputs sum, cout, plus the msb carry-in for overflow.
- add_sub_pipe instantiates STAGES slices in a generate loop.

Test Plan (N=16, CHUNK=4, STAGES=4):
- Add, ctrl=0, a=0x0005, b=0x0003, out_ready=1 -> result=0x0008, cb=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- Sub with borrow, ctrl=1, a=0x0003, b=0x0005 -> result=0xFFFE, cb=1, ovf=0. Sub, a=b=0x1234 -> result=0, zero=1, cb=0.
- Carry across every slice, ctrl=0, a=0xFFFF, b=0x0001 -> result=0x0000, cb=1, zero=1. Signed overflow, a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1. With ADD_SUB_SAT_EN and sat=1 -> result=0x7FFF, ovf=1.
- Back-to-back stream of 8 ops, out_ready=1 -> 8 results in order on 8 consecutive cycles, in_ready never drops.
- Backpressure: hold out_ready=0 for 5 cycles while streaming -> result/flags stable, in_ready=0, no loss or duplication once out_ready=1.
- Reset mid-stream: rst=1 for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, outputs zero, no stale results emitted afterwards.

Source files
------------

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared types and helpers for the pipelined adder-subtractor.
//   op_e      - operation select carried with each transaction (add / subtract)
//   flags_t   - registered status flags {cb, ovf, zero}
//   sat_limit - signed max (neg=0) or signed min (neg=1) for a given width,
//               zero-extended to MAX_W bits
package add_sub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cb;
        logic ovf;
        logic zero;
    } flags_t;

    localparam int unsigned MAX_W = 64;

    function automatic logic [MAX_W-1:0] sat_limit(input int unsigned width, input logic neg);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 < width) begin
                v[i] = !neg;
            end else if (i + 1 == width) begin
                v[i] = neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/add_sub_if.sv
// add_sub_if: operand/result handshake bundle for add_sub_pipe.
//   in_valid/in_ready   - operand transaction handshake
//   ctrl                - 0 = add, 1 = subtract
//   a, b                - N-bit operands
//   sat                 - saturate on overflow (only with ADD_SUB_SAT_EN defined)
//   out_valid/out_ready - result transaction handshake
//   result              - N-bit result
//   cb_bit, ovf, zero   - carry/borrow, signed overflow, zero flags
// Modports: master drives operands and out_ready; slave is the adder.
interface add_sub_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic         ctrl;
    logic [N-1:0] a;
    logic [N-1:0] b;
`ifdef ADD_SUB_SAT_EN
    logic         sat;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         cb_bit;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, ctrl, a, b,
`ifdef ADD_SUB_SAT_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, result, cb_bit, ovf, zero
    );

    modport slave (
        input  in_valid, ctrl, a, b,
`ifdef ADD_SUB_SAT_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, result, cb_bit, ovf, zero
    );

endinterface

// File: rtl/add_sub_slice.sv
// add_sub_slice: W-bit combinational ripple slice of the pipelined adder.
//   a_i, b_i   - operand chunks (b_i already inverted for subtract)
//   cin_i      - carry into the slice
//   sum_o      - W-bit sum chunk
//   cout_o     - carry out of the slice
//   msb_cin_o  - carry into the slice msb, used for signed overflow
module add_sub_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         msb_cin_o
);

    logic [W:0] total;

    assign total     = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign sum_o     = total[W-1:0];
    assign cout_o    = total[W];
    // sum msb = a ^ b ^ carry-in, so the carry-in falls back out of the xor
    assign msb_cin_o = a_i[W-1] ^ b_i[W-1] ^ sum_o[W-1];

endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined adder-subtractor, one CHUNK-bit slice per stage with
// the carry registered between slices. N must be a multiple of CHUNK.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, discards everything in flight
//   bus  - add_sub_if slave: operand handshake in, result + flags out
// Optional build macro ADD_SUB_SAT_EN adds bus.sat: clamp to signed max/min
// on overflow instead of wrapping.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst,
    add_sub_if.slave bus
);

    localparam int unsigned STAGES = N / CHUNK;
    localparam int unsigned NREG   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int unsigned L      = STAGES - 1;

    logic en;

    // Stage k working set: operands/control seen by slice k, which is also
    // what gets registered into stage register k.
    logic         v_d    [STAGES];
    op_e          op_d   [STAGES];
    logic [N-1:0] a_d    [STAGES];
    logic [N-1:0] bx_d   [STAGES];
    logic [N-1:0] res_in [STAGES];
    logic [N-1:0] res_d  [STAGES];
    logic         cin    [STAGES];

    logic [CHUNK-1:0] sum     [STAGES];
    logic             cout    [STAGES];
    logic             msb_cin [STAGES];

    // Inter-stage registers (stage register k feeds slice k+1)
    logic         v_q   [NREG];
    op_e          op_q  [NREG];
    logic [N-1:0] a_q   [NREG];
    logic [N-1:0] bx_q  [NREG];
    logic [N-1:0] res_q [NREG];
    logic         c_q   [NREG];

`ifdef ADD_SUB_SAT_EN
    logic             sat_d [STAGES];
    logic             sat_q [NREG];
    logic [MAX_W-1:0] lim;
`endif

    logic         ovf_fin;
    logic [N-1:0] result_d;
    flags_t       flags_d;
    logic         out_valid_q;
    logic [N-1:0] result_q;
    flags_t       flags_q;

    assign en           = !out_valid_q | bus.out_ready;
    assign bus.in_ready = en & !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        add_sub_slice #(.W(CHUNK)) u_slice (
            .a_i      (a_d[k][k*CHUNK +: CHUNK]),
            .b_i      (bx_d[k][k*CHUNK +: CHUNK]),
            .cin_i    (cin[k]),
            .sum_o    (sum[k]),
            .cout_o   (cout[k]),
            .msb_cin_o(msb_cin[k])
        );
    end

    always_comb begin : stage_inputs
        v_d[0]    = bus.in_valid;
        op_d[0]   = op_e'(bus.ctrl);
        a_d[0]    = bus.a;
        bx_d[0]   = bus.b ^ {N{bus.ctrl}};
        res_in[0] = '0;
        cin[0]    = bus.ctrl;
`ifdef ADD_SUB_SAT_EN
        sat_d[0]  = bus.sat;
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_d[k]    = v_q[k-1];
            op_d[k]   = op_q[k-1];
            a_d[k]    = a_q[k-1];
            bx_d[k]   = bx_q[k-1];
            res_in[k] = res_q[k-1];
            cin[k]    = c_q[k-1];
`ifdef ADD_SUB_SAT_EN
            sat_d[k]  = sat_q[k-1];
`endif
        end
    end

    // Splice each slice's chunk into the partial result it travels with
    always_comb begin : stage_results
        for (int unsigned k = 0; k < STAGES; k++) begin
            res_d[k]                  = res_in[k];
            res_d[k][k*CHUNK +: CHUNK] = sum[k];
        end
    end

    always_comb begin : final_stage
        result_d = res_d[L];
        ovf_fin  = cout[L] ^ msb_cin[L];
`ifdef ADD_SUB_SAT_EN
        lim = '0;
        if (sat_d[L] && ovf_fin) begin
            // a msb picks the overflow direction: 0 -> positive, 1 -> negative
            lim      = sat_limit(N, a_d[L][N-1]);
            result_d = lim[N-1:0];
        end
`endif
        flags_d.cb   = cout[L] ^ (op_d[L] == OP_SUB);
        flags_d.ovf  = ovf_fin;
        flags_d.zero = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                v_q[k]   <= 1'b0;
                op_q[k]  <= OP_ADD;
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                res_q[k] <= '0;
                c_q[k]   <= 1'b0;
`ifdef ADD_SUB_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
        end else if (en) begin
            for (int unsigned k = 0; k + 1 < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                op_q[k]  <= op_d[k];
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                res_q[k] <= res_d[k];
                c_q[k]   <= cout[k];
`ifdef ADD_SUB_SAT_EN
                sat_q[k] <= sat_d[k];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en) begin
            out_valid_q <= v_d[L];
            if (v_d[L]) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cb_bit    = flags_q.cb;
    assign bus.ovf       = flags_q.ovf;
    assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: directed self-checking bench for add_sub_pipe (N=16, CHUNK=4).
// Saturation vectors are included when ADD_SUB_SAT_EN is defined.
module tb_add_sub_pipe;

    localparam int unsigned N     = 16;
    localparam int unsigned CHUNK = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    add_sub_if #(.N(N)) bus ();

    add_sub_pipe #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        ctrl;
        logic        sat;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        cb;
        logic        ovf;
        logic        zero;
    } vec_t;

    // ctrl, sat, a, b, result, cb, ovf, zero
    vec_t singles [9] = '{
        '{1'b0, 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1},
        '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1},
        '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1},
        '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0}
    };

`ifdef ADD_SUB_SAT_EN
    vec_t sat_singles [4] = '{
        '{1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b1, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0}
    };
`endif

    vec_t stream_v [8] = '{
        '{1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0, 1'b0},
        '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1}
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        bus.ctrl = v.ctrl;
        bus.a    = v.a;
        bus.b    = v.b;
`ifdef ADD_SUB_SAT_EN
        bus.sat  = v.sat;
`endif
    endtask

    function automatic logic [31:0] obs_out();
        return {13'd0, bus.cb_bit, bus.ovf, bus.zero, bus.result};
    endfunction

    function automatic logic [31:0] exp_out(input vec_t v);
        return {13'd0, v.cb, v.ovf, v.zero, v.res};
    endfunction

    // One isolated transaction: checks accept, latency, result/flags and drain.
    task automatic run_single(input vec_t v, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        drive_op(v);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1 check_eq({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check_eq({tag, "_latency"}, lat, 32'd4);
        check_eq({tag, "_out"}, obs_out(), exp_out(v));
        @(negedge clk);
        #1 check_eq({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    // Streams stream_v; out_ready is low for stall_len cycles from cycle stall_at.
    task automatic run_stream(input int stall_at, input int stall_len, input string tag);
        int sent = 0;
        int got = 0;
        int first_c = -1;
        int last_c = -1;
        int extra = 0;
        bit ir_drop = 1'b0;
        bit holding = 1'b0;
        logic [31:0] held = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if (holding) begin
                check_eq({tag, "_hold_stable"}, obs_out(), held);
            end
            bus.out_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (sent < 8) begin
                drive_op(stream_v[sent]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            holding = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                check_eq({tag, "_stall_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
                held    = obs_out();
                holding = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq({tag, "_out"}, obs_out(), exp_out(stream_v[got]));
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            if (sent < 8) begin
                if (bus.in_ready) sent++;
                else if (stall_len == 0) ir_drop = 1'b1;
            end
        end
        check_eq({tag, "_count"}, got, 32'd8);
        if (stall_len == 0) begin
            check_eq({tag, "_first_cycle"}, first_c, 32'd4);
            check_eq({tag, "_consecutive"}, last_c - first_c, 32'd7);
            check_eq({tag, "_in_ready_drop"}, {31'd0, ir_drop}, 32'd0);
        end
        bus.in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1 if (bus.out_valid) extra++;
        end
        check_eq({tag, "_no_extra"}, extra, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stale;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ctrl      = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef ADD_SUB_SAT_EN
        bus.sat       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("rst_out", obs_out(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_single(singles[i], $sformatf("single%0d", i));
        end
`ifdef ADD_SUB_SAT_EN
        for (int i = 0; i < 4; i++) begin
            run_single(sat_singles[i], $sformatf("sat%0d", i));
        end
`endif

        run_stream(99, 0, "stream");
        run_stream(6, 5, "bp");

        // Reset with three transactions in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(stream_v[i]);
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1 check_eq("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("midrst_out", obs_out(), 32'd0);
        rst   = 1'b0;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            #1 if (bus.out_valid) stale++;
        end
        check_eq("midrst_stale", stale, 32'd0);

        run_single(singles[7], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
